// File: rtl/wshb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave between N masters.
// A per-grant transfer quota forces rotation so a streaming master cannot starve others.
module wshb_rr_arbiter #(
    parameter int N          = 2,
    parameter int DATA_BYTES = 4,
    parameter int AW         = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [N-1:0]               m_cyc,
    input  logic [N-1:0]               m_stb,
    input  logic [N-1:0]               m_we,
    input  logic [N*AW-1:0]            m_adr,
    input  logic [N*8*DATA_BYTES-1:0]  m_dat_w,
    input  logic [N*DATA_BYTES-1:0]    m_sel,
    output logic [N-1:0]               m_ack,
    output logic [8*DATA_BYTES-1:0]    m_dat_r,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [AW-1:0]              s_adr,
    output logic [8*DATA_BYTES-1:0]    s_dat_w,
    output logic [DATA_BYTES-1:0]      s_sel,
    input  logic                       s_ack,
    input  logic [8*DATA_BYTES-1:0]    s_dat_r,
    output logic [N-1:0]               grant
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            owner_cyc;
    logic            quota_hit;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan starts just after the last owner, so the previous owner is considered last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        for (int k = 1; k <= N; k++) begin
            if (!pick_vld && m_cyc[wrap_idx(last_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(last_q, k);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_GRANT) grant[last_q] = 1'b1;
    end

    assign owner_cyc = m_cyc[last_q];
    assign quota_hit = (state_q == ST_GRANT) && (hold_cnt_q == HW'(MAX_HOLD))
                       && (|(m_cyc & ~grant));

    assign s_we    = m_we[last_q];
    assign s_adr   = m_adr[int'(last_q) * AW +: AW];
    assign s_dat_w = m_dat_w[int'(last_q) * DW +: DW];
    assign s_sel   = m_sel[int'(last_q) * DATA_BYTES +: DATA_BYTES];
    assign m_dat_r = s_dat_r;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        m_ack      = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d    = ST_GRANT;
                    last_d     = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                s_cyc = owner_cyc;
                s_stb = m_stb[last_q] & ~quota_hit;
                if (s_cyc && s_stb && s_ack) begin
                    m_ack[last_q] = 1'b1;
                    if (hold_cnt_q != HW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + HW'(1);
                end
                // An owner dropping cyc takes priority over a quota release.
                if (!owner_cyc)     state_d = ST_IDLE;
                else if (quota_hit) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(N - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Self-checking bench for wshb_rr_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a cycle-level reference model.
module tb_wshb_rr_arbiter;

    localparam int N          = 3;
    localparam int DATA_BYTES = 4;
    localparam int AW         = 32;
    localparam int MAX_HOLD   = 4;
    localparam int DW         = 8 * DATA_BYTES;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          m_cyc, m_stb, m_we, m_ack;
    logic [N*AW-1:0]       m_adr;
    logic [N*DW-1:0]       m_dat_w;
    logic [N*DATA_BYTES-1:0] m_sel;
    logic [DW-1:0]         m_dat_r;
    logic                  s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]         s_adr;
    logic [DW-1:0]         s_dat_w, s_dat_r;
    logic [DATA_BYTES-1:0] s_sel;
    logic [N-1:0]          grant;

    int n_pass  = 0;
    int n_total = 0;

    wshb_rr_arbiter #(
        .N(N), .DATA_BYTES(DATA_BYTES), .AW(AW), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .sys_clk(clk),     .sys_rst(rst),
        .m_cyc(m_cyc),     .m_stb(m_stb),     .m_we(m_we),
        .m_adr(m_adr),     .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_ack(m_ack),     .m_dat_r(m_dat_r),
        .s_cyc(s_cyc),     .s_stb(s_stb),     .s_we(s_we),
        .s_adr(s_adr),     .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_ack(s_ack),     .s_dat_r(s_dat_r),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic         ack;
        logic [N-1:0] e_grant;
        logic         e_scyc;
        logic         e_sstb;
        logic [N-1:0] e_mack;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic [N-1:0] cyc, input logic [N-1:0] stb,
                        input logic ack);
        @(negedge clk);
        rst   = r;
        m_cyc = cyc;
        m_stb = stb;
        s_ack = ack;
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [N-1:0] g, input logic sc,
                             input logic ss, input logic [N-1:0] ma);
        check({tag, "_grant"}, grant, g);
        check({tag, "_scyc"}, s_cyc, sc);
        check({tag, "_sstb"}, s_stb, ss);
        check({tag, "_mack"}, m_ack, ma);
    endtask

    // Reference model state: owner index (-1 = none), release pending, rr pointer, count.
    int mdl_owner, mdl_ptr, mdl_cnt;
    bit mdl_rel;

    initial begin
        int own;
        int acks;
        logic [N-1:0] e_grant, e_mack;
        logic e_scyc, e_sstb, quota;

        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = 3'b101;
        m_adr   = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        m_dat_w = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        m_sel   = 12'hF31;
        s_ack   = 1'b0;
        s_dat_r = 32'h1234_5678;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check_bus("reset", 3'b000, 1'b0, 1'b0, 3'b000);

        // rst, cyc, stb, ack, grant, s_cyc, s_stb, m_ack
        tbl[0]  = '{1'b1, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[1]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[2]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[3]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[4]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[5]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[6]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b0, 3'b000};
        tbl[7]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[8]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[9]  = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
        tbl[10] = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
        tbl[11] = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
        tbl[12] = '{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
        tbl[13] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b010, 1'b0, 1'b0, 3'b000};
        tbl[14] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[15] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[16] = '{1'b1, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        tbl[17] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].ack);
            check_bus($sformatf("tbl%0d", i), tbl[i].e_grant, tbl[i].e_scyc,
                      tbl[i].e_sstb, tbl[i].e_mack);
            if (tbl[i].e_scyc) begin
                own = 0;
                for (int j = 0; j < N; j++) if (tbl[i].e_grant[j]) own = j;
                check($sformatf("tbl%0d_adr", i), s_adr, 32'hA000_0000 + own);
                check($sformatf("tbl%0d_datw", i), s_dat_w, 32'hD000_0000 + own);
            end
        end

        // Single master 1 streaming 40 reads, never released
        m_we = 3'b000;
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check("t2_latency_grant", grant, 3'b000);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s_dat_r = $urandom;
            #1;
            check("t2_grant", grant, 3'b010);
            check("t2_rdata", m_dat_r, s_dat_r);
            if (m_ack == 3'b010) acks++;
        end
        check("t2_ack_count", acks, 40);
        step(1'b0, 3'b000, 3'b000, 1'b1);
        check_bus("t2_drop", 3'b010, 1'b0, 1'b0, 3'b000);

        // Master 0 drops after 2 transfers while master 1 waits
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check("t4_idle_grant", grant, 3'b000);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check_bus("t4_x1", 3'b001, 1'b1, 1'b1, 3'b001);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check_bus("t4_x2", 3'b001, 1'b1, 1'b1, 3'b001);
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check_bus("t4_drop", 3'b001, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check("t4_idle2_grant", grant, 3'b000);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b011, 3'b011, 1'b1);
            check("t4_m1_grant", grant, 3'b010);
            if (m_ack == 3'b010) acks++;
        end
        check("t4_m1_transfers", acks, 4);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check_bus("t4_quota", 3'b010, 1'b1, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check_bus("t4_release", 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check("t4_idle3_grant", grant, 3'b000);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check("t4_rotate_grant", grant, 3'b001);

        // Reset mid-burst with owner 1, hold count 2
        step(1'b1, 3'b000, 3'b000, 1'b1);
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check("t6_idle_grant", grant, 3'b000);
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check_bus("t6_x1", 3'b010, 1'b1, 1'b1, 3'b010);
        step(1'b0, 3'b010, 3'b010, 1'b1);
        check_bus("t6_x2", 3'b010, 1'b1, 1'b1, 3'b010);
        step(1'b1, 3'b011, 3'b011, 1'b1);
        check("t6_pre_rst_grant", grant, 3'b010);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check_bus("t6_post_rst", 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b011, 1'b1);
        check("t6_first_owner", grant, 3'b001);

        // Randomized traffic against the reference model
        step(1'b1, 3'b000, 3'b000, 1'b0);
        mdl_owner = -1; mdl_ptr = N - 1; mdl_cnt = 0; mdl_rel = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(0, 7) != 0);
                else          m_cyc[i] = ($urandom_range(0, 3) == 0);
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
            end
            m_we    = N'($urandom);
            m_adr   = {$urandom, $urandom, $urandom};
            m_dat_w = {$urandom, $urandom, $urandom};
            m_sel   = 12'($urandom);
            s_ack   = ($urandom_range(0, 3) != 0);
            s_dat_r = $urandom;
            #1;

            e_grant = '0; e_mack = '0; e_scyc = 1'b0; e_sstb = 1'b0; quota = 1'b0;
            if (mdl_owner >= 0) begin
                e_grant[mdl_owner] = 1'b1;
                e_scyc = m_cyc[mdl_owner];
                quota  = (mdl_cnt == MAX_HOLD) && ((m_cyc & ~e_grant) != '0);
                e_sstb = m_stb[mdl_owner] && !quota;
                if (e_scyc && e_sstb && s_ack) e_mack[mdl_owner] = 1'b1;
            end
            check_bus("rnd", e_grant, e_scyc, e_sstb, e_mack);
            check("rnd_rdata", m_dat_r, s_dat_r);
            if (e_scyc) begin
                check("rnd_adr", s_adr, m_adr[mdl_owner*AW +: AW]);
                check("rnd_we", s_we, m_we[mdl_owner]);
                check("rnd_datw", s_dat_w, m_dat_w[mdl_owner*DW +: DW]);
                check("rnd_sel", s_sel, m_sel[mdl_owner*DATA_BYTES +: DATA_BYTES]);
            end

            if (rst) begin
                mdl_owner = -1; mdl_ptr = N - 1; mdl_cnt = 0; mdl_rel = 1'b0;
            end else if (mdl_owner >= 0) begin
                if (!m_cyc[mdl_owner]) mdl_owner = -1;
                else if (quota) begin
                    mdl_owner = -1;
                    mdl_rel   = 1'b1;
                end else if (e_mack != '0 && mdl_cnt < MAX_HOLD) mdl_cnt++;
            end else if (mdl_rel) begin
                mdl_rel = 1'b0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (mdl_owner < 0 && m_cyc[(mdl_ptr + k) % N]) begin
                        mdl_owner = (mdl_ptr + k) % N;
                        mdl_cnt   = 0;
                    end
                end
                if (mdl_owner >= 0) mdl_ptr = mdl_owner;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
